load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access to a word-organised data RAM with
// fixed latency, byte-lane stores, sign/zero-extended loads and fault reporting.
module load_store_unit #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned LAT   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        rsp_valid,
   output logic        err
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [1:0]      off_q, off_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            rsp_q, rsp_d;
   logic            rdy_q, rdy_d;

   logic [31:0]     mem [DEPTH];

   logic            bad_c;
   logic            mem_we_c;
   logic [3:0]      be_c;
   logic [31:0]     lane_c;
   logic [31:0]     rd_word_c;
   logic [31:0]     shifted_c;
   logic [31:0]     load_c;
   logic            unused_addr_c;

   assign unused_addr_c = ^ALUResult[31:AW+2];

   // Illegal size/sign encoding or misaligned half/word address
   always_comb begin
      bad_c = 1'b0;
      if (funct3[1:0] == 2'b11 || funct3 == 3'b110) bad_c = 1'b1;
      if (MemWrite && funct3[2])                      bad_c = 1'b1;
      if (funct3[1:0] == 2'b01 && ALUResult[0])       bad_c = 1'b1;
      if (funct3[1:0] == 2'b10 && ALUResult[1:0] != 2'b00) bad_c = 1'b1;
   end

   // Lane enables and replicated store data for the latched access
   always_comb begin
      be_c   = 4'b1111;
      lane_c = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            be_c   = 4'(4'b0001 << off_q);
            lane_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_c   = off_q[1] ? 4'b1100 : 4'b0011;
            lane_c = {2{wdata_q[15:0]}};
         end
         default: begin
            be_c   = 4'b1111;
            lane_c = wdata_q;
         end
      endcase
   end

   // Load extraction and extension
   always_comb begin
      rd_word_c = mem[idx_q];
      shifted_c = rd_word_c >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
         3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
         3'b100:  load_c = {24'd0, shifted_c[7:0]};
         3'b101:  load_c = {16'd0, shifted_c[15:0]};
         default: load_c = rd_word_c;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      f3_d     = f3_q;
      idx_d    = idx_q;
      off_d    = off_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      mem_we_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = MemWrite;
               f3_d    = funct3;
               idx_d   = ALUResult[AW+1:2];
               off_d   = ALUResult[1:0];
               wdata_d = WriteData;
               if (bad_c) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CW'(LAT - 1);
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d  = RESP;
               mem_we_c = we_q;
               err_d    = 1'b0;
               rdata_d  = we_q ? 32'd0 : load_c;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rsp_d = (state_d == RESP);
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         idx_q   <= '0;
         off_q   <= 2'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         rsp_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         rsp_q   <= rsp_d;
         rdy_q   <= rdy_d;
      end
   end

   // RAM is not reset; a reset mid-access leaves state_q out of BUSY so no write occurs
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[idx_q][8*i +: 8] <= lane_c[8*i +: 8];
         end
      end
   end

   assign req_ready = rdy_q;
   assign rsp_valid = rsp_q;
   assign err       = err_q;
   assign ReadData  = rdata_q;
endmodule
